// File: rtl/l2tlb_pkg.sv
// Shared types and sizing for the L2 TLB miss sequencer.
package l2tlb_pkg;

   localparam int VPN_W      = 36;
   localparam int TLB_DATA_W = 64;
   localparam int SET_BITS   = 7;
   localparam int NUM_SETS   = 1 << SET_BITS;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WALK_REQ,
      WALK_WAIT,
      FILL,
      FLUSH
   } state_t;

   // dst: 0 = instruction side, 1 = data side
   typedef struct packed {
      logic [VPN_W-1:0] vpn;
      logic             dst;
   } req_t;

endpackage

// File: rtl/l2tlb_rr_arb2.sv
// Two-way round-robin grant; the pointer only moves when both sides compete.
module l2tlb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = '0;
      if (en) begin
         if (&req) gnt[ptr] = 1'b1;
         else      gnt      = req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             ptr <= 1'b0;
      else if (en && &req) ptr <= ~ptr;
   end

endmodule

// File: rtl/l2tlb_miss_ctrl.sv
// L2 TLB miss sequencer: arbitrates I/D misses, looks up, walks, fills, and sweeps on flush.
module l2tlb_miss_ctrl
   import l2tlb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ireq_vld,
   input  logic [VPN_W-1:0]      ireq_vpn,
   output logic                  ireq_rdy,
   input  logic                  dreq_vld,
   input  logic [VPN_W-1:0]      dreq_vpn,
   output logic                  dreq_rdy,
   output logic                  rsp_vld,
   output logic                  rsp_dst,
   output logic                  rsp_fault,
   output logic [TLB_DATA_W-1:0] rsp_data,
   output logic                  tlb_rd_en,
   output logic [SET_BITS-1:0]   tlb_rd_addr,
   output logic [VPN_W-1:0]      tlb_rd_vpn,
   input  logic                  tlb_hit,
   input  logic [TLB_DATA_W-1:0] tlb_hit_data,
   output logic [SET_BITS-1:0]   tlb_wr_addr,
   output logic [TLB_DATA_W-1:0] tlb_wr_data,
   output logic                  tlb_wr_wen,
   output logic                  tlb_wr_invl,
   output logic                  walk_req_vld,
   output logic [VPN_W-1:0]      walk_req_vpn,
   input  logic                  walk_req_rdy,
   input  logic                  walk_rsp_vld,
   input  logic                  walk_rsp_fault,
   input  logic [TLB_DATA_W-1:0] walk_rsp_data,
   input  logic                  flush_req,
   output logic                  flush_busy
);

   state_t                state, state_nxt;
   req_t                  cur, cur_nxt;
   logic [TLB_DATA_W-1:0] ent, ent_nxt;
   logic [SET_BITS-1:0]   idx, idx_nxt;
   logic                  flush_pend, pend_nxt;
   logic                  init;
   logic                  arb_en;
   logic [1:0]            gnt;

   // init holds the first cycle after reset release quiet, so nothing is accepted then
   assign arb_en = (state == IDLE) && !init && !flush_pend && !flush_req;

   l2tlb_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en),
      .req ({dreq_vld, ireq_vld}),
      .gnt (gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur        <= '0;
         ent        <= '0;
         idx        <= '0;
         flush_pend <= 1'b0;
         init       <= 1'b1;
      end else begin
         state      <= state_nxt;
         cur        <= cur_nxt;
         ent        <= ent_nxt;
         idx        <= idx_nxt;
         flush_pend <= pend_nxt;
         init       <= 1'b0;
      end
   end

   always_comb begin
      state_nxt    = state;
      cur_nxt      = cur;
      ent_nxt      = ent;
      idx_nxt      = idx;
      pend_nxt     = flush_pend;
      ireq_rdy     = 1'b0;
      dreq_rdy     = 1'b0;
      rsp_vld      = 1'b0;
      rsp_dst      = 1'b0;
      rsp_fault    = 1'b0;
      rsp_data     = '0;
      tlb_rd_en    = 1'b0;
      tlb_rd_addr  = '0;
      tlb_rd_vpn   = '0;
      tlb_wr_addr  = '0;
      tlb_wr_data  = '0;
      tlb_wr_wen   = 1'b0;
      tlb_wr_invl  = 1'b0;
      walk_req_vld = 1'b0;
      walk_req_vpn = '0;
      flush_busy   = 1'b0;

      case (state)
         IDLE: begin
            if (!init) begin
               if (flush_pend || flush_req) begin
                  state_nxt = FLUSH;
                  idx_nxt   = '0;
                  pend_nxt  = 1'b0;
               end else if (|gnt) begin
                  cur_nxt.dst = gnt[1];
                  cur_nxt.vpn = gnt[1] ? dreq_vpn : ireq_vpn;
                  ireq_rdy    = gnt[0];
                  dreq_rdy    = gnt[1];
                  tlb_rd_en   = 1'b1;
                  tlb_rd_addr = cur_nxt.vpn[SET_BITS-1:0];
                  tlb_rd_vpn  = cur_nxt.vpn;
                  state_nxt   = LOOKUP;
               end
            end
         end
         LOOKUP: begin
            if (tlb_hit) begin
               rsp_vld   = 1'b1;
               rsp_dst   = cur.dst;
               rsp_data  = tlb_hit_data;
               state_nxt = IDLE;
            end else begin
               state_nxt = WALK_REQ;
            end
         end
         WALK_REQ: begin
            walk_req_vld = 1'b1;
            walk_req_vpn = cur.vpn;
            if (walk_req_rdy) state_nxt = WALK_WAIT;
         end
         WALK_WAIT: begin
            if (walk_rsp_vld) begin
               if (walk_rsp_fault) begin
                  rsp_vld   = 1'b1;
                  rsp_dst   = cur.dst;
                  rsp_fault = 1'b1;
                  rsp_data  = walk_rsp_data;
                  state_nxt = IDLE;
               end else begin
                  ent_nxt   = walk_rsp_data;
                  state_nxt = FILL;
               end
            end
         end
         FILL: begin
            tlb_wr_wen  = 1'b1;
            tlb_wr_addr = cur.vpn[SET_BITS-1:0];
            tlb_wr_data = ent;
            rsp_vld     = 1'b1;
            rsp_dst     = cur.dst;
            rsp_data    = ent;
            state_nxt   = IDLE;
         end
         FLUSH: begin
            tlb_wr_invl = 1'b1;
            tlb_wr_addr = idx;
            flush_busy  = 1'b1;
            idx_nxt     = idx + 1'b1;
            if (&idx) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // a flush arriving mid-operation waits for that operation to finish
      if (flush_req && (init || (state != IDLE && state != FLUSH))) pend_nxt = 1'b1;
   end

endmodule

// File: tb/tb_l2tlb_miss_ctrl.sv
// Directed bench for l2tlb_miss_ctrl; responses are checked by a scoreboard monitor.
module tb_l2tlb_miss_ctrl;

   logic        clk;
   logic        rst;
   logic        ireq_vld, dreq_vld, ireq_rdy, dreq_rdy;
   logic [35:0] ireq_vpn, dreq_vpn, tlb_rd_vpn, walk_req_vpn;
   logic        rsp_vld, rsp_dst, rsp_fault;
   logic [63:0] rsp_data, tlb_hit_data, tlb_wr_data, walk_rsp_data;
   logic        tlb_rd_en, tlb_hit, tlb_wr_wen, tlb_wr_invl;
   logic [6:0]  tlb_rd_addr, tlb_wr_addr;
   logic        walk_req_vld, walk_req_rdy, walk_rsp_vld, walk_rsp_fault;
   logic        flush_req, flush_busy;

   l2tlb_miss_ctrl dut (
      .clk(clk), .rst(rst),
      .ireq_vld(ireq_vld), .ireq_vpn(ireq_vpn), .ireq_rdy(ireq_rdy),
      .dreq_vld(dreq_vld), .dreq_vpn(dreq_vpn), .dreq_rdy(dreq_rdy),
      .rsp_vld(rsp_vld), .rsp_dst(rsp_dst), .rsp_fault(rsp_fault), .rsp_data(rsp_data),
      .tlb_rd_en(tlb_rd_en), .tlb_rd_addr(tlb_rd_addr), .tlb_rd_vpn(tlb_rd_vpn),
      .tlb_hit(tlb_hit), .tlb_hit_data(tlb_hit_data),
      .tlb_wr_addr(tlb_wr_addr), .tlb_wr_data(tlb_wr_data),
      .tlb_wr_wen(tlb_wr_wen), .tlb_wr_invl(tlb_wr_invl),
      .walk_req_vld(walk_req_vld), .walk_req_vpn(walk_req_vpn), .walk_req_rdy(walk_req_rdy),
      .walk_rsp_vld(walk_rsp_vld), .walk_rsp_fault(walk_rsp_fault), .walk_rsp_data(walk_rsp_data),
      .flush_req(flush_req), .flush_busy(flush_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        dst;
      logic        fault;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic dst, input logic fault, input logic [63:0] data);
      exp_q.push_back({dst, fault, data});
   endtask

   // scoreboard monitor plus per-cycle exclusivity invariants
   always @(negedge clk) begin
      if (!rst) begin
         chk("rdy_exclusive", 64'(ireq_rdy & dreq_rdy), 64'd0);
         chk("wen_invl_exclusive", 64'(tlb_wr_wen & tlb_wr_invl), 64'd0);
         if (rsp_vld) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp_dst", 64'(rsp_dst), 64'(e.dst));
               chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
               chk("rsp_data", rsp_data, e.data);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      ireq_vld = 1'b1; ireq_vpn = 36'h0; dreq_vld = 1'b0; dreq_vpn = 36'h0;
      tlb_hit = 1'b0; tlb_hit_data = 64'h0;
      walk_req_rdy = 1'b0; walk_rsp_vld = 1'b0; walk_rsp_fault = 1'b0; walk_rsp_data = 64'h0;
      flush_req = 1'b0;

      // reset: outputs quiet during reset and in the first cycle after release
      @(negedge clk);
      chk("rst_ireq_rdy", 64'(ireq_rdy), 64'd0);
      chk("rst_rd_en", 64'(tlb_rd_en), 64'd0);
      chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ireq_rdy", 64'(ireq_rdy), 64'd0);
      chk("post_rst_rd_en", 64'(tlb_rd_en), 64'd0);

      // lone hit on the data side
      cyc();
      ireq_vld = 1'b0;
      dreq_vld = 1'b1; dreq_vpn = 36'h123;
      @(negedge clk);
      chk("hit_dreq_rdy", 64'(dreq_rdy), 64'd1);
      chk("hit_ireq_rdy", 64'(ireq_rdy), 64'd0);
      chk("hit_rd_en", 64'(tlb_rd_en), 64'd1);
      chk("hit_rd_addr", 64'(tlb_rd_addr), 64'h23);
      chk("hit_rd_vpn", 64'(tlb_rd_vpn), 64'h123);
      cyc();
      dreq_vld = 1'b0; tlb_hit = 1'b1; tlb_hit_data = 64'h1111;
      push(1'b1, 1'b0, 64'h1111);
      @(negedge clk);
      chk("hit_rsp_vld", 64'(rsp_vld), 64'd1);
      chk("hit_no_walk", 64'(walk_req_vld), 64'd0);
      cyc();
      tlb_hit = 1'b0;

      // miss, walker stalls 3 cycles, fill
      ireq_vld = 1'b1; ireq_vpn = 36'h4A5;
      @(negedge clk);
      chk("miss_ireq_rdy", 64'(ireq_rdy), 64'd1);
      chk("miss_rd_addr", 64'(tlb_rd_addr), 64'h25);
      cyc();
      ireq_vld = 1'b0;
      @(negedge clk);
      chk("miss_lookup_rsp", 64'(rsp_vld), 64'd0);
      chk("miss_lookup_walk", 64'(walk_req_vld), 64'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         walk_req_rdy = (i == 3);
         @(negedge clk);
         chk("walk_req_vld_held", 64'(walk_req_vld), 64'd1);
         chk("walk_req_vpn", 64'(walk_req_vpn), 64'h4A5);
      end
      cyc();
      walk_req_rdy = 1'b0;
      walk_rsp_vld = 1'b1; walk_rsp_data = 64'hDEAD;
      @(negedge clk);
      chk("walk_wait_req_drop", 64'(walk_req_vld), 64'd0);
      chk("walk_wait_no_rsp", 64'(rsp_vld), 64'd0);
      cyc();
      walk_rsp_vld = 1'b0;
      push(1'b0, 1'b0, 64'hDEAD);
      @(negedge clk);
      chk("fill_wen", 64'(tlb_wr_wen), 64'd1);
      chk("fill_addr", 64'(tlb_wr_addr), 64'h25);
      chk("fill_data", tlb_wr_data, 64'hDEAD);
      chk("fill_rsp_vld", 64'(rsp_vld), 64'd1);

      // contention: grants alternate I, D, I, D
      tlb_hit = 1'b1; tlb_hit_data = 64'hAAAA;
      for (int i = 0; i < 8; i++) begin
         cyc();
         ireq_vld = 1'b1; ireq_vpn = 36'h10;
         dreq_vld = 1'b1; dreq_vpn = 36'h20;
         if (i % 2 == 0) push(logic'((i / 2) % 2), 1'b0, 64'hAAAA);
         @(negedge clk);
         chk("cont_ireq_rdy", 64'(ireq_rdy), 64'((i % 2 == 0) && ((i / 2) % 2 == 0)));
         chk("cont_dreq_rdy", 64'(dreq_rdy), 64'((i % 2 == 0) && ((i / 2) % 2 == 1)));
      end
      cyc();
      ireq_vld = 1'b0; dreq_vld = 1'b0; tlb_hit = 1'b0;

      // walk fault: response with fault, no fill
      dreq_vld = 1'b1; dreq_vpn = 36'h77;
      @(negedge clk);
      chk("fault_dreq_rdy", 64'(dreq_rdy), 64'd1);
      cyc();
      dreq_vld = 1'b0;
      cyc();
      walk_req_rdy = 1'b1;
      cyc();
      walk_req_rdy = 1'b0;
      walk_rsp_vld = 1'b1; walk_rsp_fault = 1'b1; walk_rsp_data = 64'hBAD;
      push(1'b1, 1'b1, 64'hBAD);
      @(negedge clk);
      chk("fault_rsp_vld", 64'(rsp_vld), 64'd1);
      chk("fault_no_wen", 64'(tlb_wr_wen), 64'd0);
      cyc();
      walk_rsp_vld = 1'b0; walk_rsp_fault = 1'b0;
      @(negedge clk);
      chk("fault_no_wen_after", 64'(tlb_wr_wen), 64'd0);

      // flush during walk: fill lands first, then 128-cycle sweep
      cyc();
      ireq_vld = 1'b1; ireq_vpn = 36'h1FF;
      cyc();
      ireq_vld = 1'b0;
      cyc();
      walk_req_rdy = 1'b1;
      cyc();
      walk_req_rdy = 1'b0;
      flush_req = 1'b1;
      @(negedge clk);
      chk("flush_wait_busy", 64'(flush_busy), 64'd0);
      cyc();
      flush_req = 1'b0;
      walk_rsp_vld = 1'b1; walk_rsp_data = 64'hF00D;
      cyc();
      walk_rsp_vld = 1'b0;
      push(1'b0, 1'b0, 64'hF00D);
      @(negedge clk);
      chk("flush_fill_wen", 64'(tlb_wr_wen), 64'd1);
      chk("flush_fill_addr", 64'(tlb_wr_addr), 64'h7F);
      cyc();
      ireq_vld = 1'b1; ireq_vpn = 36'h55;
      @(negedge clk);
      chk("flush_pend_refuse", 64'(ireq_rdy), 64'd0);
      chk("flush_pend_busy", 64'(flush_busy), 64'd0);
      for (int i = 0; i < 128; i++) begin
         cyc();
         flush_req = (i == 5);
         @(negedge clk);
         chk("sweep_busy", 64'(flush_busy), 64'd1);
         chk("sweep_invl", 64'(tlb_wr_invl), 64'd1);
         chk("sweep_addr", 64'(tlb_wr_addr), 64'(i));
         chk("sweep_refuse", 64'(ireq_rdy), 64'd0);
         chk("sweep_no_rd", 64'(tlb_rd_en), 64'd0);
      end
      cyc();
      flush_req = 1'b0;
      tlb_hit = 1'b1; tlb_hit_data = 64'h5555;
      push(1'b0, 1'b0, 64'h5555);
      @(negedge clk);
      chk("post_sweep_busy", 64'(flush_busy), 64'd0);
      chk("post_sweep_accept", 64'(ireq_rdy), 64'd1);
      cyc();
      ireq_vld = 1'b0;
      cyc();
      tlb_hit = 1'b0;

      // reset in WALK_WAIT drops the request
      ireq_vld = 1'b1; ireq_vpn = 36'h33;
      cyc();
      ireq_vld = 1'b0;
      cyc();
      walk_req_rdy = 1'b1;
      cyc();
      walk_req_rdy = 1'b0;
      rst = 1'b1;
      walk_rsp_vld = 1'b1; walk_rsp_data = 64'h99;
      @(negedge clk);
      chk("rst_mid_rsp", 64'(rsp_vld), 64'd0);
      chk("rst_mid_wen", 64'(tlb_wr_wen), 64'd0);
      chk("rst_mid_walk", 64'(walk_req_vld), 64'd0);
      cyc();
      rst = 1'b0;
      walk_rsp_vld = 1'b0;
      dreq_vld = 1'b1; dreq_vpn = 36'h44;
      @(negedge clk);
      chk("rst_mid_init_rdy", 64'(dreq_rdy), 64'd0);
      cyc();
      tlb_hit = 1'b1; tlb_hit_data = 64'h4444;
      push(1'b1, 1'b0, 64'h4444);
      @(negedge clk);
      chk("rst_mid_accept", 64'(dreq_rdy), 64'd1);
      cyc();
      dreq_vld = 1'b0;
      @(negedge clk);
      chk("rst_mid_rsp_vld", 64'(rsp_vld), 64'd1);
      cyc();
      tlb_hit = 1'b0;
      cyc();
      cyc();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
